// File: rtl/freq_sweep_pkg.sv
// Shared types and helpers for the frequency sweep sequencer.
// Optional hold input is enabled with FREQ_SWEEP_HOLD_EN.
package freq_sweep_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } state_e;

    localparam int          BCD_DIGITS   = 6;
    localparam logic [23:0] FREQ_MIN_BCD = 24'h000001;

    function automatic logic bcd_valid(input logic [23:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/freq_sweep_ctrl_bcd_add6.sv
// Combinational 6-digit packed-BCD adder with carry out.
// Each digit is corrected by +6 when its binary sum exceeds 9.
module bcd_add6
    import freq_sweep_pkg::*;
(
    input  logic [23:0] a,
    input  logic [23:0] b,
    output logic [23:0] sum,
    output logic        cout
);

    logic [4:0] dsum;
    logic       c;

    always_comb begin
        sum  = '0;
        c    = 1'b0;
        dsum = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            dsum = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
            if (dsum > 5'd9) begin
                dsum = dsum + 5'd6;
                c    = 1'b1;
            end else begin
                c    = 1'b0;
            end
            sum[4*i +: 4] = dsum[3:0];
        end
        cout = c;
    end

endmodule

// File: rtl/freq_sweep_ctrl.sv
// BCD frequency sweep sequencer feeding the square-wave generator.
// Define FREQ_SWEEP_HOLD_EN to add the hold input that pauses dwell.
module freq_sweep_ctrl
    import freq_sweep_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int TICK_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        loop_mode,
    input  logic [23:0] f_start,
    input  logic [23:0] f_stop,
    input  logic [23:0] f_step,
    input  logic [15:0] dwell_ms,
`ifdef FREQ_SWEEP_HOLD_EN
    input  logic        hold,
`endif
    output logic [23:0] freq_bcd,
    output logic        busy,
    output logic        done,
    output logic        cfg_err
);

    state_e             state_q, state_d;
    logic [23:0]        freq_q, freq_d;
    logic [23:0]        start_q, start_d;
    logic [23:0]        stop_q, stop_d;
    logic [23:0]        step_q, step_d;
    logic               loop_q, loop_d;
    logic [15:0]        dwell_q, dwell_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [15:0]        ms_q, ms_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [23:0]        nxt;
    logic               nxt_cout;
    logic               cfg_ok;
    logic               tick_wrap;
    logic               pt_end;
    logic               run;

`ifdef FREQ_SWEEP_HOLD_EN
    assign run = ~hold;
`else
    assign run = 1'b1;
`endif

    bcd_add6 u_add (
        .a    (freq_q),
        .b    (step_q),
        .sum  (nxt),
        .cout (nxt_cout)
    );

    // Packed-BCD magnitude compare is the same as a plain unsigned compare.
    assign cfg_ok = bcd_valid(f_start) && bcd_valid(f_stop)
                 && bcd_valid(f_step) && (f_start != '0)
                 && (f_step != '0) && (f_start <= f_stop);

    assign tick_wrap = (tick_q == TICK_W'(TICK_DIV - 1));
    assign pt_end    = tick_wrap && (ms_q == dwell_q - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            freq_q  <= FREQ_MIN_BCD;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            loop_q  <= 1'b0;
            dwell_q <= '0;
            tick_q  <= '0;
            ms_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            step_q  <= step_d;
            loop_q  <= loop_d;
            dwell_q <= dwell_d;
            tick_q  <= tick_d;
            ms_q    <= ms_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        start_d = start_q;
        stop_d  = stop_q;
        step_d  = step_q;
        loop_d  = loop_q;
        dwell_d = dwell_q;
        tick_d  = tick_q;
        ms_d    = ms_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (cfg_ok) begin
                        state_d = DWELL;
                        freq_d  = f_start;
                        start_d = f_start;
                        stop_d  = f_stop;
                        step_d  = f_step;
                        loop_d  = loop_mode;
                        dwell_d = (dwell_ms == '0) ? 16'd1 : dwell_ms;
                        tick_d  = '0;
                        ms_d    = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DWELL: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (run) begin
                    if (tick_wrap) begin
                        tick_d = '0;
                        if (pt_end) begin
                            ms_d = '0;
                            if (!nxt_cout && nxt <= stop_q) begin
                                freq_d = nxt;
                            end else if (loop_q) begin
                                freq_d = start_q;
                            end else begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            ms_d = ms_q + 16'd1;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        freq_bcd = freq_q;
        busy     = (state_q == DWELL);
        done     = done_q;
        cfg_err  = err_q;
    end

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Self-checking bench for freq_sweep_ctrl with TICK_DIV = 4.
// Exercises the hold input when FREQ_SWEEP_HOLD_EN is defined.
module tb_freq_sweep_ctrl;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        loop_mode = 1'b0;
    logic [23:0] f_start = 24'h000001;
    logic [23:0] f_stop = 24'h000001;
    logic [23:0] f_step = 24'h000001;
    logic [15:0] dwell_ms = 16'd1;
    logic        hold = 1'b0;
    logic [23:0] freq_bcd;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int nchk = 0;
    int nfail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    freq_sweep_ctrl #(.TICK_DIV(TD), .TICK_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .loop_mode (loop_mode),
        .f_start   (f_start),
        .f_stop    (f_stop),
        .f_step    (f_step),
        .dwell_ms  (dwell_ms),
`ifdef FREQ_SWEEP_HOLD_EN
        .hold      (hold),
`endif
        .freq_bcd  (freq_bcd),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    function automatic bit digits_ok(input logic [23:0] v);
        for (int i = 0; i < 6; i++)
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int to_dec(input logic [23:0] v);
        int r = 0;
        for (int i = 5; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [23:0] to_bcd(input int n);
        logic [23:0] r;
        int x = n;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [23:0] got,
                         input logic [23:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Reference model: a point is a countdown of dwell*TD cycles.
    bit          m_busy, m_done, m_err, m_loop;
    logic [23:0] m_freq, m_start, m_stop, m_step;
    int          m_rem, m_dw, m_nxt;

    initial begin
        m_busy = 0; m_done = 0; m_err = 0; m_loop = 0;
        m_freq = 24'h000001; m_start = '0; m_stop = '0; m_step = '0;
        m_rem = 0; m_dw = 1; m_nxt = 0;
        forever begin
            @(posedge clk);
            m_done = 0;
            m_err  = 0;
            if (rst) begin
                m_busy = 0;
                m_freq = 24'h000001;
            end else if (!m_busy) begin
                if (start && !abort) begin
                    if (digits_ok(f_start) && digits_ok(f_stop) &&
                        digits_ok(f_step) && to_dec(f_start) > 0 &&
                        to_dec(f_step) > 0 &&
                        to_dec(f_start) <= to_dec(f_stop)) begin
                        m_start = f_start;
                        m_stop  = f_stop;
                        m_step  = f_step;
                        m_loop  = loop_mode;
                        m_dw    = (dwell_ms == 0) ? 1 : int'(dwell_ms);
                        m_rem   = m_dw * TD;
                        m_freq  = f_start;
                        m_busy  = 1;
                    end else begin
                        m_err = 1;
                    end
                end
            end else if (abort) begin
                m_busy = 0;
            end else if (!hold) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_nxt = to_dec(m_freq) + to_dec(m_step);
                    if (m_nxt <= to_dec(m_stop)) m_freq = to_bcd(m_nxt);
                    else if (m_loop) m_freq = m_start;
                    else begin
                        m_busy = 0;
                        m_done = 1;
                    end
                    m_rem = m_dw * TD;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("freq_bcd", freq_bcd, m_freq);
            check("busy", {23'd0, busy}, {23'd0, m_busy});
            check("done", {23'd0, done}, {23'd0, m_done});
            check("cfg_err", {23'd0, cfg_err}, {23'd0, m_err});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [23:0] s, input logic [23:0] e,
                           input logic [23:0] st, input logic [15:0] dw,
                           input logic lp);
        f_start = s; f_stop = e; f_step = st; dwell_ms = dw; loop_mode = lp;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        step(1);
        abort = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        step(3);
        chk_en = 1'b1;
        check("rst_freq", freq_bcd, 24'h000001);
        check("rst_busy", {23'd0, busy}, 24'd0);
        check("rst_done", {23'd0, done}, 24'd0);
        rst = 1'b0;
        step(2);

        // Single sweep 100..130 step 10, dwell 2 -> 8 cycles per point
        set_cfg(24'h000100, 24'h000130, 24'h000010, 16'd2, 1'b0);
        pulse_start();
        check("sw_p0", freq_bcd, 24'h000100);
        step(7);
        check("sw_p0_end", freq_bcd, 24'h000100);
        step(1);
        check("sw_p1", freq_bcd, 24'h000110);
        step(8);
        check("sw_p2", freq_bcd, 24'h000120);
        step(8);
        check("sw_p3", freq_bcd, 24'h000130);
        step(8);
        check("sw_done", {23'd0, done}, 24'd1);
        check("sw_busy", {23'd0, busy}, 24'd0);
        check("sw_hold", freq_bcd, 24'h000130);
        step(1);
        check("sw_done_pulse", {23'd0, done}, 24'd0);

        // BCD carry: 95, 102, 109, 116
        set_cfg(24'h000095, 24'h000200, 24'h000007, 16'd1, 1'b0);
        pulse_start();
        check("bcd_95", freq_bcd, 24'h000095);
        step(4);
        check("bcd_102", freq_bcd, 24'h000102);
        step(4);
        check("bcd_109", freq_bcd, 24'h000109);
        step(4);
        check("bcd_116", freq_bcd, 24'h000116);
        pulse_abort();
        check("abort_hold", freq_bcd, 24'h000116);

        // Config errors
        set_cfg(24'h000100, 24'h000200, 24'h000000, 16'd1, 1'b0);
        pulse_start();
        check("err_step0", {23'd0, cfg_err}, 24'd1);
        check("err_freq", freq_bcd, 24'h000116);
        step(1);
        check("err_pulse", {23'd0, cfg_err}, 24'd0);
        set_cfg(24'h0A0000, 24'h200000, 24'h000001, 16'd1, 1'b0);
        pulse_start();
        check("err_nibble", {23'd0, cfg_err}, 24'd1);
        set_cfg(24'h000300, 24'h000200, 24'h000001, 16'd1, 1'b0);
        pulse_start();
        check("err_order", {23'd0, cfg_err}, 24'd1);
        check("err_idle", {23'd0, busy}, 24'd0);
        step(2);

        // dwell 0 behaves as 1 ms
        set_cfg(24'h000005, 24'h000007, 24'h000001, 16'd0, 1'b0);
        pulse_start();
        step(4);
        check("dw0_6", freq_bcd, 24'h000006);
        step(8);
        check("dw0_done", {23'd0, done}, 24'd1);
        step(2);

        // Overflow with loop: carry reloads start, no done
        set_cfg(24'h999990, 24'h999999, 24'h000020, 16'd1, 1'b1);
        pulse_start();
        step(8);
        check("ovf_reload", freq_bcd, 24'h999990);
        check("ovf_busy", {23'd0, busy}, 24'd1);
        pulse_abort();

        // Abort on the end-of-point cycle
        set_cfg(24'h000010, 24'h000050, 24'h000010, 16'd1, 1'b0);
        pulse_start();
        step(3);
        pulse_abort();
        check("coll_freq", freq_bcd, 24'h000010);
        check("coll_done", {23'd0, done}, 24'd0);
        check("coll_busy", {23'd0, busy}, 24'd0);

        // Start during DWELL is ignored
        set_cfg(24'h000200, 24'h000400, 24'h000100, 16'd1, 1'b0);
        pulse_start();
        step(1);
        f_start = 24'h000700;
        pulse_start();
        step(2);
        check("restart_ign", freq_bcd, 24'h000300);
        pulse_abort();

        // Start and abort together in IDLE
        set_cfg(24'h000001, 24'h000009, 24'h000001, 16'd1, 1'b0);
        start = 1'b1; abort = 1'b1;
        step(1);
        start = 1'b0; abort = 1'b0;
        check("sa_busy", {23'd0, busy}, 24'd0);

        // Reset mid-sweep
        pulse_start();
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mid_rst_freq", freq_bcd, 24'h000001);
        check("mid_rst_busy", {23'd0, busy}, 24'd0);

`ifdef FREQ_SWEEP_HOLD_EN
        // 10-cycle hold stretches an 8-cycle point to 18
        set_cfg(24'h000300, 24'h000400, 24'h000001, 16'd2, 1'b0);
        pulse_start();
        hold = 1'b1;
        step(10);
        hold = 1'b0;
        step(7);
        check("hold_same", freq_bcd, 24'h000300);
        step(1);
        check("hold_next", freq_bcd, 24'h000301);
        pulse_abort();
`endif

        // Randomized sweeps against the model
        for (int it = 0; it < 30; it++) begin
            int s, n;
            logic [23:0] fs;
            s  = int'($urandom_range(1, 60));
            fs = to_bcd(s);
            if ($urandom_range(0, 9) == 0) fs[15:12] = 4'hB;
            set_cfg(fs, to_bcd(s + int'($urandom_range(0, 60)) - 3),
                    to_bcd(int'($urandom_range(0, 15))),
                    16'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            pulse_start();
            n = int'($urandom_range(5, 80));
            for (int c = 0; c < n; c++) begin
                abort = ($urandom_range(0, 39) == 0);
                start = ($urandom_range(0, 19) == 0);
`ifdef FREQ_SWEEP_HOLD_EN
                hold  = ($urandom_range(0, 3) == 0);
`endif
                step(1);
            end
            start = 1'b0;
            hold  = 1'b0;
            pulse_abort();
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b1;
                step(1);
                rst = 1'b0;
            end
        end

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
